// File: rtl/mem_seq_writer.sv
// Sequential RAM writer: loads a valid/ready byte stream at incrementing addresses
// starting at 0, with a registered random-access read port. Optional macro: MEM_SEQ_WRITER_WRAP_EN.
module mem_seq_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wrap_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  accept;
    logic                  last_beat;

    // start_i has priority: a beat presented alongside a restart is dropped.
    assign accept    = (state_q == LOAD) && valid_i && !start_i;
    assign last_beat = accept && (addr_q == ADDR_LAST);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (start_i) begin
            state_d = LOAD;
            addr_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        addr_d = addr_q + 1'b1;
                        if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
                    end
`ifdef MEM_SEQ_WRITER_WRAP_EN
                    if (stop_i) state_d = DONE;
`else
                    if (stop_i || last_beat) state_d = DONE;
`endif
                end
                IDLE, DONE: state_d = state_q;
                default:    state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM and survives rst_i.
    always_ff @(posedge clk_i) begin
        if (accept) mem[addr_q] <= data_i;
    end

    // Read-before-write: a same-address write in this cycle is not visible yet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_data_q <= '0;
        else       rd_data_q <= mem[rd_addr_i];
    end

`ifdef MEM_SEQ_WRITER_WRAP_EN
    logic wrap_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          wrap_q <= 1'b0;
        else if (start_i)   wrap_q <= 1'b0;
        else if (last_beat) wrap_q <= 1'b1;
    end

    assign wrap_o = wrap_q;
`else
    assign wrap_o = 1'b0;
`endif

    assign ready_o   = (state_q == LOAD);
    assign busy_o    = (state_q == LOAD);
    assign done_o    = (state_q == DONE);
    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;

endmodule
